guess_ctrl: RTL
===============

# guess_ctrl

Game sequencer for the guess-number board: collects a 4-digit secret (question phase) and 4-digit guesses (answer phase) from the keypad, scores each guess, and drives the dot-matrix display's control inputs (`digit_state`, `qa_state`, `match`, `state`). It sits between the keypad decoder and the dot-matrix driver, on the same `clk_div` clock. It also exports hit/blow counts and an attempt count for the 7-segment display.

## Interface
- `HOLD_CYCLES`, default 2000: number of `clk_div` cycles the result face is shown; legal range ≥ 1.
- `clk_div`  in  1  system/display clock.
- `reset`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid in the same cycle.
- `key_code`  in  4  0–9 are digits; 4'hF is clear; every other code is ignored.
- `digit_state`  out  2  index of the next digit to enter (0–3).
- `qa_state`  out  1  phase: 0 = question (secret entry), 1 = answer (guess entry).
- `match`  out  1  1 while the result is displayed.
- `state`  out  2  result code: 0 none, 1 good, 2 bad.
- `hits`  out  3  digits with the right value in the right position (0–4).
- `blows`  out  3  digits with the right value in the wrong position (0–4).
- `attempts`  out  4  number of guesses scored since the secret was set; saturates at 15.

## Operation
- **FSM states:** Q_ENTRY, A_ENTRY, COMPARE, RESULT.
- **Reset values:** FSM = Q_ENTRY; `digit_state` = 0, `qa_state` = 0, `match` = 0, `state` = 0, `hits` = 0, `blows` = 0, `attempts` = 0; secret and guess registers all 0.
- **Q_ENTRY / A_ENTRY digit keys:**
  - An accepted digit is written to slot `digit_state` of the secret (Q) or guess (A) register, and `digit_state` increments.
  - A digit that equals a digit already entered in the current entry is rejected: no write, no increment.
- **Clear (4'hF) in either entry state:** `digit_state` = 0. Slot contents are don't-care after clear.
- **Entry complete:**
  - Accepting the 4th secret digit: go to A_ENTRY, `qa_state` = 1, `digit_state` = 0.
  - Accepting the 4th guess digit: go to COMPARE, `digit_state` = 0.
- **COMPARE (exactly one cycle):**
  - Register `hits` and `blows`.
  - `attempts` = `attempts` + 1, saturating at 15.
  - Go to RESULT with `match` = 1; `state` = 1 if hits == 4, otherwise 2.
- **RESULT:**
  - A hold counter runs for HOLD_CYCLES cycles.
  - At expiry: `match` = 0 and `state` = 0.
  - If the result was good: go to Q_ENTRY, `qa_state` = 0, `attempts` = 0.
  - If the result was bad: go to A_ENTRY, keeping the secret and `attempts`.
  - `hits` and `blows` hold their values until the next COMPARE.
- **Ignored keys:** all keys are ignored in COMPARE and RESULT. Codes 4'hA–4'hE are ignored in every state.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- **Key latency:** a key accepted at edge N is reflected in `digit_state`/`qa_state` after edge N.
- **4th guess digit accepted at edge N:**
  - Edge N+1: COMPARE; `hits`, `blows`, `attempts` update.
  - Edge N+2: `match` = 1 and `state` valid.
  - `match` then stays high for exactly HOLD_CYCLES cycles.
- **Reset wins:** `reset` high at any edge, including mid-entry or mid-RESULT, applies all reset values at that edge.
- **Strobe width:** each `key_valid` pulse counts once; back-to-back strobes on consecutive cycles are each evaluated.

## Configuration
- Macro: `GUESS_BLOW_EN`.
- **Defined:** `blows` is computed as the count of (i≠j, guess[i]==secret[j]).
- **Undefined:** `blows` is tied to 0 and the cross-position compare logic is not built. `hits`, `state`, and FSM behaviour are unchanged.

## Structure
- **Package `guess_pkg`:**
  - FSM state enum.
  - Result codes RES_NONE = 0, RES_GOOD = 1, RES_BAD = 2.
  - Key constants KEY_CLEAR = 4'hF and DIGIT_MAX = 9.
  - Type for a 4 × 4-bit digit array.
- **Sub-module `guess_score`:** combinational scorer taking secret and guess arrays and producing `hits` and `blows`. The blow logic inside it is guarded by `GUESS_BLOW_EN`.

## Test plan
- **Reset:** assert `reset` for 2 cycles → `digit_state` 0, `qa_state` 0, `match` 0, `state` 0, `attempts` 0.
- **Secret entry:** keys 1, 2, 3, 4 → `digit_state` steps 1, 2, 3, then `qa_state` = 1 with `digit_state` = 0.
- **Correct guess:** guess 1, 2, 3, 4 (HOLD_CYCLES = 5) → 2 cycles later `match` = 1, `state` = 1, `hits` = 4, `attempts` = 1. After 5 cycles: `match` = 0, `qa_state` = 0, `attempts` = 0.
- **Wrong guess:** guess 4, 3, 2, 1 → `state` = 2, `hits` = 0, `blows` = 4 with `GUESS_BLOW_EN` and 0 without. After the hold: `qa_state` = 1, `attempts` = 1.
- **Key filtering:** keys 5, 5, B, F → the second 5 and the B are ignored (`digit_state` stays 1), then F clears `digit_state` to 0.
- **Reset mid-result:** assert `reset` during RESULT → all outputs at reset values on the next cycle; the next key 7 is stored as secret slot 0.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared types and constants for the guess-number game sequencer.
package guess_pkg;

    typedef enum logic [1:0] {
        Q_ENTRY = 2'd0,
        A_ENTRY = 2'd1,
        COMPARE = 2'd2,
        RESULT  = 2'd3
    } fsm_e;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_GOOD = 2'd1;
    localparam logic [1:0] RES_BAD  = 2'd2;

    localparam logic [3:0] KEY_CLEAR = 4'hF;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Four 4-bit digits, slot 0 is the first digit entered.
    typedef logic [3:0][3:0] digits_t;

    // True when key already sits in one of the first n slots of d.
    function automatic logic digit_seen(input digits_t d, input logic [1:0] n,
                                        input logic [3:0] key);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((2'(k) < n) && (d[k] == key)) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
        end
        return seen;
    endfunction

endpackage

// File: rtl/guess_score.sv
// Combinational scorer: hits (same value, same slot) and blows (same value,
// other slot). Blow logic is only built when GUESS_BLOW_EN is defined.
module guess_score
    import guess_pkg::*;
(
    input  digits_t    secret_i,
    input  digits_t    guess_i,
    output logic [2:0] hits_o,
    output logic [2:0] blows_o
);

    // Count positional matches.
    always_comb begin
        hits_o = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (secret_i[i] == guess_i[i]) begin
                hits_o = hits_o + 3'd1;
            end else begin
                hits_o = hits_o;
            end
        end
    end

`ifdef GUESS_BLOW_EN
    logic [4:0] blow_cnt_s;

    // Count cross-position matches; clamp to 4 in case digits were not unique.
    always_comb begin
        blow_cnt_s = 5'd0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if ((i != j) && (guess_i[i] == secret_i[j])) begin
                    blow_cnt_s = blow_cnt_s + 5'd1;
                end else begin
                    blow_cnt_s = blow_cnt_s;
                end
            end
        end
        if (blow_cnt_s > 5'd4) begin
            blows_o = 3'd4;
        end else begin
            blows_o = blow_cnt_s[2:0];
        end
    end
`else
    assign blows_o = 3'd0;
`endif

endmodule

// File: rtl/guess_ctrl.sv
// Guess-number game sequencer: secret entry, guess entry, scoring and result
// hold. Optional blow counting is enabled with the GUESS_BLOW_EN macro.
module guess_ctrl
    import guess_pkg::*;
#(
    parameter int HOLD_CYCLES = 2000
) (
    input  logic       clk_div,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [1:0] digit_state,
    output logic       qa_state,
    output logic       match,
    output logic [1:0] state,
    output logic [2:0] hits,
    output logic [2:0] blows,
    output logic [3:0] attempts
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    fsm_e          fsm_q, fsm_d;
    logic [1:0]    digit_q, digit_d;
    logic          qa_q, qa_d;
    logic          match_q, match_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    hits_q, hits_d;
    logic [2:0]    blows_q, blows_d;
    logic [3:0]    attempts_q, attempts_d;
    digits_t       secret_q, secret_d;
    digits_t       guess_q, guess_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [2:0]    score_hits_s;
    logic [2:0]    score_blows_s;
    digits_t       entry_s;
    logic          in_answer_s;
    logic          key_digit_s;
    logic          key_clear_s;

    guess_score u_score (
        .secret_i (secret_q),
        .guess_i  (guess_q),
        .hits_o   (score_hits_s),
        .blows_o  (score_blows_s)
    );

    assign in_answer_s = (fsm_q == A_ENTRY);
    assign entry_s     = in_answer_s ? guess_q : secret_q;
    assign key_digit_s = key_valid && (key_code <= DIGIT_MAX);
    assign key_clear_s = key_valid && (key_code == KEY_CLEAR);

    // Next-state and output logic for the game sequencer.
    always_comb begin
        fsm_d      = fsm_q;
        digit_d    = digit_q;
        qa_d       = qa_q;
        match_d    = match_q;
        state_d    = state_q;
        hits_d     = hits_q;
        blows_d    = blows_q;
        attempts_d = attempts_q;
        secret_d   = secret_q;
        guess_d    = guess_q;
        hold_d     = hold_q;

        case (fsm_q)
            Q_ENTRY, A_ENTRY: begin
                if (key_clear_s) begin
                    digit_d = 2'd0;
                end else if (key_digit_s && !digit_seen(entry_s, digit_q, key_code)) begin
                    if (in_answer_s) begin
                        guess_d[digit_q] = key_code;
                    end else begin
                        secret_d[digit_q] = key_code;
                    end
                    if (digit_q == 2'd3) begin
                        digit_d = 2'd0;
                        qa_d    = 1'b1;
                        fsm_d   = in_answer_s ? COMPARE : A_ENTRY;
                    end else begin
                        digit_d = digit_q + 2'd1;
                    end
                end else begin
                    digit_d = digit_q;
                end
            end
            COMPARE: begin
                hits_d  = score_hits_s;
                blows_d = score_blows_s;
                if (attempts_q == 4'd15) begin
                    attempts_d = 4'd15;
                end else begin
                    attempts_d = attempts_q + 4'd1;
                end
                hold_d = '0;
                fsm_d  = RESULT;
            end
            RESULT: begin
                // First RESULT cycle raises the face; match then spans HOLD_CYCLES.
                if (!match_q) begin
                    match_d = 1'b1;
                    state_d = (hits_q == 3'd4) ? RES_GOOD : RES_BAD;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    match_d = 1'b0;
                    state_d = RES_NONE;
                    if (state_q == RES_GOOD) begin
                        fsm_d      = Q_ENTRY;
                        qa_d       = 1'b0;
                        attempts_d = 4'd0;
                    end else begin
                        fsm_d = A_ENTRY;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                fsm_d = Q_ENTRY;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_div) begin
        if (reset) begin
            fsm_q      <= Q_ENTRY;
            digit_q    <= 2'd0;
            qa_q       <= 1'b0;
            match_q    <= 1'b0;
            state_q    <= RES_NONE;
            hits_q     <= 3'd0;
            blows_q    <= 3'd0;
            attempts_q <= 4'd0;
            secret_q   <= '0;
            guess_q    <= '0;
            hold_q     <= '0;
        end else begin
            fsm_q      <= fsm_d;
            digit_q    <= digit_d;
            qa_q       <= qa_d;
            match_q    <= match_d;
            state_q    <= state_d;
            hits_q     <= hits_d;
            blows_q    <= blows_d;
            attempts_q <= attempts_d;
            secret_q   <= secret_d;
            guess_q    <= guess_d;
            hold_q     <= hold_d;
        end
    end

    assign digit_state = digit_q;
    assign qa_state    = qa_q;
    assign match       = match_q;
    assign state       = state_q;
    assign hits        = hits_q;
    assign blows       = blows_q;
    assign attempts    = attempts_q;

endmodule
